// File: rtl/ota_trim_sar_ctrl.sv
// OTA offset-trim calibration controller: MSB-first successive approximation over
// the trim-DAC code, with a majority vote per bit and a manual override path.
module ota_trim_sar_ctrl #(
    parameter int unsigned TRIM_BITS     = 6,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned VOTES         = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 cmp_in,
    input  logic                 manual_mode,
    input  logic [TRIM_BITS-1:0] manual_code,
    output logic [TRIM_BITS-1:0] trim_code,
    output logic                 busy,
    output logic                 done,
    output logic                 cal_ok
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > VOTES) ? SETTLE_CYCLES : VOTES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned ONES_W  = $clog2(VOTES + 1);
    localparam int unsigned K_W     = $clog2(TRIM_BITS);
    localparam logic [TRIM_BITS-1:0] MIDSCALE = {1'b1, {(TRIM_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DECIDE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [TRIM_BITS-1:0] code_q, code_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ONES_W-1:0]    ones_q, ones_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cal_ok_q, cal_ok_d;
    logic [1:0]           sync_q;
    logic                 cmp_s;

    assign cmp_s = sync_q[1];

    // State, datapath and output registers, plus the comparator synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            code_q   <= MIDSCALE;
            k_q      <= '0;
            cnt_q    <= '0;
            ones_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cal_ok_q <= 1'b0;
            sync_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cal_ok_q <= cal_ok_d;
            sync_q   <= {sync_q[0], cmp_in};
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        ones_d   = ones_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cal_ok_d = cal_ok_q;

        if (state_q != IDLE && !ena) begin
            state_d  = IDLE;
            code_d   = MIDSCALE;
            busy_d   = 1'b0;
            cal_ok_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (manual_mode) begin
                        code_d = manual_code;
                    end else if (ena && start) begin
                        code_d   = MIDSCALE;
                        k_d      = K_W'(TRIM_BITS - 1);
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        cal_ok_d = 1'b0;
                        state_d  = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        ones_d  = '0;
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    ones_d = ones_q + ONES_W'(cmp_s);
                    if (cnt_q == CNT_W'(VOTES - 1)) begin
                        cnt_d   = '0;
                        state_d = DECIDE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DECIDE: begin
                    // Comparator high means the trial code is still at or below target
                    code_d[k_q] = (ones_q > ONES_W'(VOTES / 2));
                    if (k_q != '0) begin
                        code_d[k_q - K_W'(1)] = 1'b1;
                        k_d                   = k_q - K_W'(1);
                        state_d               = SETTLE;
                    end else begin
                        done_d   = 1'b1;
                        cal_ok_d = (code_d != '0) && (code_d != '1);
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign trim_code = code_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cal_ok    = cal_ok_q;

endmodule

// File: tb/tb_ota_trim_sar_ctrl.sv
// Directed bench for ota_trim_sar_ctrl: table of full calibrations plus hand-written
// manual, abort, restart and asynchronous-reset sequences.
module tb_ota_trim_sar_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       cmp_in;
    logic       manual_mode;
    logic [5:0] manual_code;
    logic [5:0] trim_code;
    logic       busy;
    logic       done;
    logic       cal_ok;

    int   mode;
    logic glitch;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct packed {
        logic [1:0]      mode;
        logic            gl;
        logic [5:0][5:0] trial;
        logic [5:0]      fin;
        logic            ok;
    } vec_t;

    vec_t vecs [4];

    ota_trim_sar_ctrl #(
        .TRIM_BITS    (6),
        .SETTLE_CYCLES(16),
        .VOTES        (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .cmp_in     (cmp_in),
        .manual_mode(manual_mode),
        .manual_code(manual_code),
        .trim_code  (trim_code),
        .busy       (busy),
        .done       (done),
        .cal_ok     (cal_ok)
    );

    always #5 clk = ~clk;

    // Comparator model: 0 = stuck low, 1 = stuck high, 2 = OTA with target code 37
    always_comb begin
        if (mode == 2) cmp_in = (trim_code <= 6'd37) ^ glitch;
        else           cmp_in = (mode == 1) ^ glitch;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_cal(input vec_t v, input int restart_at, input string tag);
        int done_at;
        int done_n;
        int busy_n;
        done_at = -1;
        done_n  = 0;
        busy_n  = 0;
        mode    = int'(v.mode);
        glitch  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            if (c <= 120 && (c - 1) % 20 == 0)
                chk({tag, " trial"}, int'(trim_code), int'(v.trial[(c - 1) / 20]));
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            glitch = v.gl && (c % 20 == 16) && (c <= 120);
            start  = (c == restart_at);
            @(negedge clk);
        end
        glitch = 1'b0;
        start  = 1'b0;
        chk({tag, " done_cycle"}, done_at, 121);
        chk({tag, " done_pulses"}, done_n, 1);
        chk({tag, " busy_cycles"}, busy_n, 121);
        chk({tag, " final_code"}, int'(trim_code), int'(v.fin));
        chk({tag, " cal_ok"}, int'(cal_ok), int'(v.ok));
    endtask

    initial begin
        int cnt;
        rst_n       = 1'b1;
        ena         = 1'b1;
        start       = 1'b0;
        manual_mode = 1'b0;
        manual_code = 6'd0;
        mode        = 0;
        glitch      = 1'b0;

        vecs[0] = '{mode: 2'd1, gl: 1'b0, fin: 6'd63, ok: 1'b0,
                    trial: {6'd63, 6'd62, 6'd60, 6'd56, 6'd48, 6'd32}};
        vecs[1] = '{mode: 2'd0, gl: 1'b0, fin: 6'd0, ok: 1'b0,
                    trial: {6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32}};
        vecs[2] = '{mode: 2'd2, gl: 1'b0, fin: 6'd37, ok: 1'b1,
                    trial: {6'd37, 6'd38, 6'd36, 6'd40, 6'd48, 6'd32}};
        vecs[3] = '{mode: 2'd2, gl: 1'b1, fin: 6'd37, ok: 1'b1,
                    trial: {6'd37, 6'd38, 6'd36, 6'd40, 6'd48, 6'd32}};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset trim", int'(trim_code), 32);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset cal_ok", int'(cal_ok), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset trim", int'(trim_code), 32);

        for (int i = 0; i < 4; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_cal(vecs[i], 0, tag);
        end

        // Manual override in IDLE; start is ignored while manual_mode is high
        manual_mode = 1'b1;
        manual_code = 6'd5;
        @(negedge clk);
        chk("manual trim", int'(trim_code), 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("manual start busy", int'(busy), 0);
        chk("manual start trim", int'(trim_code), 5);
        @(negedge clk);
        chk("manual start busy2", int'(busy), 0);
        manual_mode = 1'b0;

        // Abort by dropping ena during the third bit's settle window
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 45; c++) begin
            if (c == 41) chk("abort third trial", int'(trim_code), 40);
            @(negedge clk);
        end
        ena = 1'b0;
        @(negedge clk);
        chk("abort trim", int'(trim_code), 32);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort cal_ok", int'(cal_ok), 0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) cnt++;
            @(negedge clk);
        end
        chk("abort quiet", cnt, 0);
        ena = 1'b1;

        // Fresh calibration with a second start pulse while busy
        do_cal(vecs[2], 30, "restart");

        // Asynchronous reset mid-calibration takes effect before any clock edge
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("pre-reset busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset trim", int'(trim_code), 32);
        chk("async reset busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("after reset busy", int'(busy), 0);
        chk("after reset trim", int'(trim_code), 32);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
